// File: rtl/pca_pkg.sv
// Shared definitions for the PCA covariance front end: FSM states, BRAM word
// addresses of the 2x2 covariance matrix and the BRAM data width.
package pca_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_ACCUM,
      ST_DRAIN,
      ST_WRITE,
      ST_DONE
   } state_e;

   localparam logic [1:0] COV_XX = 2'd0;
   localparam logic [1:0] COV_XY = 2'd1;
   localparam logic [1:0] COV_YX = 2'd2;
   localparam logic [1:0] COV_YY = 2'd3;

   localparam int COV_DATA_W = 32;

endpackage

// File: rtl/cov_mac.sv
// Multiply-accumulate core: registers the three sample products on accept and
// folds them into the Sxx/Sxy/Syy accumulators on the following edge.
module cov_mac
   import pca_pkg::*;
#(
   parameter int DATA_W = 16,
   parameter int LOG2_N = 2
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           clear,
   input  logic                           en,
   input  logic [DATA_W-1:0]              x_in,
   input  logic [DATA_W-1:0]              y_in,
   output logic [2*DATA_W+LOG2_N-1:0]     sxx,
   output logic [2*DATA_W+LOG2_N-1:0]     sxy,
   output logic [2*DATA_W+LOG2_N-1:0]     syy
);

   localparam int PROD_W = 2 * DATA_W;
   localparam int ACC_W  = PROD_W + LOG2_N;

   logic signed [PROD_W-1:0] x_ext, y_ext;
   logic signed [PROD_W-1:0] xx_d, xx_q, xy_d, xy_q, yy_d, yy_q;
   logic                     prod_vld_d, prod_vld_q;
   logic signed [ACC_W-1:0]  sxx_d, sxx_q, sxy_d, sxy_q, syy_d, syy_q;

   // Widening before the multiply keeps the full signed product; the product
   // of two DATA_W values always fits in PROD_W bits.
   assign x_ext = PROD_W'($signed(x_in));
   assign y_ext = PROD_W'($signed(y_in));

   always_comb begin
      // NOTE: every variable gets its hold value first so no path leaves one
      // unassigned, which is what would otherwise infer a latch.
      xx_d       = xx_q;
      xy_d       = xy_q;
      yy_d       = yy_q;
      prod_vld_d = 1'b0;
      sxx_d      = sxx_q;
      sxy_d      = sxy_q;
      syy_d      = syy_q;
      if (clear) begin
         sxx_d = '0;
         sxy_d = '0;
         syy_d = '0;
      end else begin
         if (en) begin
            xx_d       = x_ext * x_ext;
            xy_d       = x_ext * y_ext;
            yy_d       = y_ext * y_ext;
            prod_vld_d = 1'b1;
         end
         if (prod_vld_q) begin
            sxx_d = sxx_q + ACC_W'(xx_q);
            sxy_d = sxy_q + ACC_W'(xy_q);
            syy_d = syy_q + ACC_W'(yy_q);
         end
      end
   end

   // NOTE: state is updated with non-blocking assignments so every flop samples
   // the pre-edge values regardless of process ordering.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         xx_q       <= '0;
         xy_q       <= '0;
         yy_q       <= '0;
         prod_vld_q <= 1'b0;
         sxx_q      <= '0;
         sxy_q      <= '0;
         syy_q      <= '0;
      end else begin
         xx_q       <= xx_d;
         xy_q       <= xy_d;
         yy_q       <= yy_d;
         prod_vld_q <= prod_vld_d;
         sxx_q      <= sxx_d;
         sxy_q      <= sxy_d;
         syy_q      <= syy_d;
      end
   end

   assign sxx = sxx_q;
   assign sxy = sxy_q;
   assign syy = syy_q;

endmodule

// File: rtl/covariance_accumulator.sv
// Windowed 2x2 covariance of centred samples, written into the covariance BRAM
// through its single-port write interface once N samples have been summed.
module covariance_accumulator
   import pca_pkg::*;
#(
   parameter int DATA_W = 16,
   parameter int LOG2_N = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] x_in,
   input  logic [DATA_W-1:0] y_in,
   output logic              bram_ena,
   output logic              bram_wea,
   output logic [1:0]        bram_addra,
   output logic [31:0]       bram_dina,
   output logic              busy,
   output logic              done
);

   localparam int                ACC_W   = 2 * DATA_W + LOG2_N;
   localparam int                CNT_W   = LOG2_N + 1;
   localparam logic [CNT_W-1:0]  N_CNT   = CNT_W'(1 << LOG2_N);
   localparam logic [CNT_W-1:0]  N_LAST  = CNT_W'((1 << LOG2_N) - 1);
   localparam logic [2:0]        WR_LAST = 3'd4;

   state_e                 state_d, state_q;
   logic [CNT_W-1:0]       cnt_d, cnt_q;
   logic [2:0]             wcnt_d, wcnt_q;
   logic                   busy_d, busy_q;
   logic                   done_d, done_q;
   logic                   ena_d, ena_q;
   logic [1:0]             addr_d, addr_q;
   logic [COV_DATA_W-1:0]  dina_d, dina_q;

   logic                   accept;
   logic                   mac_clear;
   logic [ACC_W-1:0]       sxx, sxy, syy;
   logic signed [ACC_W-1:0] sel;

   assign in_ready = (state_q == ST_ACCUM) && (cnt_q < N_CNT);
   assign accept   = in_valid && in_ready;

   cov_mac #(
      .DATA_W (DATA_W),
      .LOG2_N (LOG2_N)
   ) u_mac (
      .clk   (clk),
      .rst   (rst),
      .clear (mac_clear),
      .en    (accept),
      .x_in  (x_in),
      .y_in  (y_in),
      .sxx   (sxx),
      .sxy   (sxy),
      .syy   (syy)
   );

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      wcnt_d    = wcnt_q;
      mac_clear = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            if (start) begin
               state_d   = ST_ACCUM;
               cnt_d     = '0;
               mac_clear = 1'b1;
            end
         end
         ST_ACCUM: begin
            if (accept) begin
               cnt_d = cnt_q + CNT_W'(1);
               if (cnt_q == N_LAST) state_d = ST_DRAIN;
            end
         end
         ST_DRAIN: begin
            state_d = ST_WRITE;
            wcnt_d  = '0;
         end
         // Four issue cycles plus one in which the last word lands in the BRAM.
         ST_WRITE: begin
            wcnt_d = wcnt_q + 3'd1;
            if (wcnt_q == WR_LAST) state_d = ST_DONE;
         end
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      unique case (wcnt_q[1:0])
         COV_XX:         sel = $signed(sxx) >>> LOG2_N;
         COV_XY, COV_YX: sel = $signed(sxy) >>> LOG2_N;
         default:        sel = $signed(syy) >>> LOG2_N;
      endcase
      ena_d  = (state_q == ST_WRITE) && (wcnt_q < WR_LAST);
      addr_d = ena_d ? wcnt_q[1:0] : 2'd0;
      dina_d = ena_d ? COV_DATA_W'(sel) : '0;
      busy_d = (state_d != ST_IDLE);
      done_d = (state_d == ST_DONE);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         wcnt_q  <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         ena_q   <= 1'b0;
         addr_q  <= '0;
         dina_q  <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         wcnt_q  <= wcnt_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         ena_q   <= ena_d;
         addr_q  <= addr_d;
         dina_q  <= dina_d;
      end
   end

   assign bram_ena   = ena_q;
   assign bram_wea   = ena_q;
   assign bram_addra = addr_q;
   assign bram_dina  = dina_q;
   assign busy       = busy_q;
   assign done       = done_q;

endmodule

// File: tb/tb_covariance_accumulator.sv
// Self-checking bench for covariance_accumulator: directed and random windows
// compared against a plain-arithmetic covariance model.
module tb_covariance_accumulator;

   localparam int DATA_W = 16;
   localparam int LOG2_N = 2;
   localparam int N      = 1 << LOG2_N;

   logic              clk = 1'b0;
   logic              rst;
   logic              start;
   logic              in_valid;
   logic              in_ready;
   logic [DATA_W-1:0] x_in;
   logic [DATA_W-1:0] y_in;
   logic              bram_ena;
   logic              bram_wea;
   logic [1:0]        bram_addra;
   logic [31:0]       bram_dina;
   logic              busy;
   logic              done;

   int checks = 0;
   int errors = 0;
   int sx[N];
   int sy[N];

   covariance_accumulator #(
      .DATA_W (DATA_W),
      .LOG2_N (LOG2_N)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .x_in       (x_in),
      .y_in       (y_in),
      .bram_ena   (bram_ena),
      .bram_wea   (bram_wea),
      .bram_addra (bram_addra),
      .bram_dina  (bram_dina),
      .busy       (busy),
      .done       (done)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Expected BRAM word: mean of the products over the window, floor-shifted.
   function automatic logic [31:0] model_word(input int addr);
      longint acc = 0;
      for (int i = 0; i < N; i++) begin
         case (addr)
            0:       acc += longint'(sx[i]) * sx[i];
            1, 2:    acc += longint'(sx[i]) * sy[i];
            default: acc += longint'(sy[i]) * sy[i];
         endcase
      end
      acc = acc >>> LOG2_N;
      return acc[31:0];
   endfunction

   task automatic load(input int x0, y0, x1, y1, x2, y2, x3, y3);
      sx[0] = x0; sy[0] = y0; sx[1] = x1; sy[1] = y1;
      sx[2] = x2; sy[2] = y2; sx[3] = x3; sy[3] = y3;
   endtask

   task automatic load_random();
      for (int i = 0; i < N; i++) begin
         sx[i] = int'($signed(16'($urandom)));
         sy[i] = int'($signed(16'($urandom)));
      end
   endtask

   task automatic check_idle_outputs(input string tag);
      check({tag, "_in_ready"}, 64'(in_ready), 64'd0);
      check({tag, "_ena"},      64'(bram_ena), 64'd0);
      check({tag, "_wea"},      64'(bram_wea), 64'd0);
      check({tag, "_addr"},     64'(bram_addra), 64'd0);
      check({tag, "_dina"},     64'(bram_dina), 64'd0);
      check({tag, "_busy"},     64'(busy), 64'd0);
      check({tag, "_done"},     64'(done), 64'd0);
   endtask

   // One window: start, feed N samples (optionally on alternate cycles),
   // optionally poke start while busy, and check every BRAM write and timing.
   // abort_after >= 0 asserts rst once that many writes have been observed.
   task automatic run_window(input string tag, input bit toggle, input bit poke, input int abort_after);
      int fed = 0, cyc = 0, wr_cnt = 0, done_cnt = 0;
      int e_cyc = -1, done_cyc = -1, idle_cyc = -1;
      bit acc_now;
      @(negedge clk);
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      check({tag, "_busy_after_start"},  64'(busy), 64'd1);
      check({tag, "_ready_after_start"}, 64'(in_ready), 64'd1);
      while (cyc < 80) begin
         in_valid = (fed < N) && (!toggle || (cyc % 2 == 1));
         x_in     = (fed < N) ? 16'(sx[fed]) : 16'hdead;
         y_in     = (fed < N) ? 16'(sy[fed]) : 16'hbeef;
         start    = poke && (cyc == 2 || cyc == N + 3);
         acc_now  = in_valid && in_ready;
         @(posedge clk);
         cyc++;
         if (acc_now) fed++;
         #1;
         start = 1'b0;
         if (acc_now && fed == N) begin
            e_cyc = cyc;
            check({tag, "_ready_low_after_last"}, 64'(in_ready), 64'd0);
         end
         if (bram_ena) begin
            if (wr_cnt < 4) begin
               check({tag, "_wea"},      64'(bram_wea), 64'd1);
               check({tag, "_addr"},     64'(bram_addra), 64'(wr_cnt));
               check({tag, "_data"},     64'(bram_dina), 64'(model_word(wr_cnt)));
               check({tag, "_wr_cycle"}, 64'(cyc), 64'(e_cyc + 2 + wr_cnt));
            end
            wr_cnt++;
         end
         if (done) begin
            done_cnt++;
            done_cyc = cyc;
         end
         if (abort_after >= 0 && wr_cnt == abort_after) begin
            #2;
            rst = 1'b1;
            #1;
            check_idle_outputs({tag, "_abort"});
            @(negedge clk);
            rst = 1'b0;
            in_valid = 1'b0;
            return;
         end
         if (done_cnt > 0 && !busy) begin
            idle_cyc = cyc;
            break;
         end
      end
      in_valid = 1'b0;
      check({tag, "_writes"},     64'(wr_cnt), 64'd4);
      check({tag, "_done_count"}, 64'(done_cnt), 64'd1);
      check({tag, "_done_cycle"}, 64'(done_cyc), 64'(e_cyc + 6));
      check({tag, "_idle_cycle"}, 64'(idle_cyc), 64'(e_cyc + 7));
      if (!toggle) check({tag, "_latency"}, 64'(done_cyc), 64'(N + 6));
   endtask

   initial begin
      rst      = 1'b1;
      start    = 1'b0;
      in_valid = 1'b0;
      x_in     = '0;
      y_in     = '0;
      #1;
      check_idle_outputs("reset");
      repeat (2) @(negedge clk);
      rst = 1'b0;

      // Samples offered while idle must not be taken.
      in_valid = 1'b1;
      repeat (3) begin
         @(posedge clk);
         #1;
         check_idle_outputs("idle_valid");
      end
      in_valid = 1'b0;

      load(1, 2, 3, 4, -1, -2, -3, -4);
      run_window("basic", 1'b0, 1'b0, -1);
      run_window("toggle", 1'b1, 1'b0, -1);
      run_window("poke", 1'b0, 1'b1, -1);

      load(-32768, -32768, -32768, -32768, -32768, -32768, -32768, -32768);
      run_window("min_val", 1'b0, 1'b0, -1);

      load(5, -3, 5, -3, 5, -3, 5, -3);
      run_window("neg_xy", 1'b0, 1'b0, -1);

      load_random();
      run_window("abort", 1'b0, 1'b0, 2);
      repeat (2) @(negedge clk);
      load_random();
      run_window("after_abort", 1'b0, 1'b0, -1);

      for (int k = 0; k < 6; k++) begin
         load_random();
         run_window($sformatf("rand%0d", k), k[0], 1'b0, -1);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
